uart_tx_arbiter: RTL and testbench

//  Shares the single UART transmitter (TX_MODULE) between NUM_REQ byte requesters.

---
 rtl/uart_tx_arbiter.sv | 164 ++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter between NUM_REQ byte requesters.
// Round-robin grant from a rotating pointer, latches the winner's byte, fires a
// one-cycle tx_start, waits for tx_done (or a watchdog timeout), then enforces an
// idle gap before the next grant. Every output comes straight from a register.
//
// Handshake: a requester raises req[i] with its byte on req_data[i*DATA_W +: DATA_W]
// and holds both until ack[i] pulses; ack[i] means the byte has been latched into
// tx_data. A req still high after ack is treated as a new request. done[i] or err[i]
// pulses once when that frame ends.
module uart_tx_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = 8,
  parameter int GAP_CYC     = 16,
  parameter int TIMEOUT_CYC = 2000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  output logic [NUM_REQ-1:0]         ack,
  output logic [NUM_REQ-1:0]         done,
  output logic [NUM_REQ-1:0]         err,
  output logic                       tx_start,
  output logic [DATA_W-1:0]          tx_data,
  input  logic                       tx_done,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic [1:0]                 dbg_state
);

  localparam int ID_W    = $clog2(NUM_REQ);
  localparam int CNT_MAX = (GAP_CYC > TIMEOUT_CYC) ? GAP_CYC : TIMEOUT_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_GAP   = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [ID_W-1:0]     ptr_q, ptr_d;
  logic [ID_W-1:0]     grant_q, grant_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [NUM_REQ-1:0]  ack_q, ack_d;
  logic [NUM_REQ-1:0]  done_q, done_d;
  logic [NUM_REQ-1:0]  err_q, err_d;
  logic                start_q, start_d;
  logic                busy_q, busy_d;

  logic                win_found;
  logic [ID_W-1:0]     win_idx;
  logic [ID_W-1:0]     cand;
  logic [ID_W-1:0]     ptr_next;

  // Round-robin search: first requester at or after the pointer, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = ID_W'((int'(ptr_q) + i) % NUM_REQ);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Pointer moves just past the requester whose frame has finished.
  assign ptr_next = (grant_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;

  // Next-state and registered-output values; shared counter serves WAIT and GAP.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    ack_d   = '0;
    done_d  = '0;
    err_d   = '0;
    start_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          state_d = S_START;
          grant_d = win_idx;
          data_d  = req_data[win_idx*DATA_W +: DATA_W];
          start_d = 1'b1;
          ack_d   = NUM_REQ'(1) << win_idx;
        end
      end
      S_START: begin
        state_d = S_WAIT;
        cnt_d   = '0;
      end
      S_WAIT: begin
        if (tx_done || (cnt_q == CNT_W'(TIMEOUT_CYC - 1))) begin
          // tx_done takes priority over a coincident timeout.
          if (tx_done) done_d = NUM_REQ'(1) << grant_q;
          else         err_d  = NUM_REQ'(1) << grant_q;
          ptr_d   = ptr_next;
          cnt_d   = '0;
          state_d = (GAP_CYC == 0) ? S_IDLE : S_GAP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_GAP: begin
        if (cnt_q == CNT_W'(GAP_CYC - 1)) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; reset abandons any frame silently.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      ack_q   <= '0;
      done_q  <= '0;
      err_q   <= '0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      done_q  <= done_d;
      err_q   <= err_d;
      start_q <= start_d;
      busy_q  <= busy_d;
    end
  end

  assign ack       = ack_q;
  assign done      = done_q;
  assign err       = err_q;
  assign tx_start  = start_q;
  assign tx_data   = data_q;
  assign busy      = busy_q;
  assign grant_id  = grant_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a table of frames (request pattern, data,
// transmitter response delay, expected grant and outcome) plus hand-written
// sequences for reset mid-frame and traffic arriving during the idle gap.
module tb_uart_tx_arbiter;

  localparam int NUM_REQ     = 4;
  localparam int DATA_W      = 8;
  localparam int GAP_CYC     = 16;
  localparam int TIMEOUT_CYC = 2000;
  localparam int NVEC        = 11;

  logic                       clk;
  logic                       reset;
  logic [NUM_REQ-1:0]         req;
  logic [NUM_REQ*DATA_W-1:0]  req_data;
  logic [NUM_REQ-1:0]         ack;
  logic [NUM_REQ-1:0]         done;
  logic [NUM_REQ-1:0]         err;
  logic                       tx_start;
  logic [DATA_W-1:0]          tx_data;
  logic                       tx_done;
  logic                       busy;
  logic [1:0]                 grant_id;
  logic [1:0]                 dbg_state;

  uart_tx_arbiter #(
    .NUM_REQ    (NUM_REQ),
    .DATA_W     (DATA_W),
    .GAP_CYC    (GAP_CYC),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .req_data (req_data),
    .ack      (ack),
    .done     (done),
    .err      (err),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .tx_done  (tx_done),
    .busy     (busy),
    .grant_id (grant_id),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] sb_exp;

  typedef struct {
    logic [3:0]  req;
    logic [31:0] data;
    logic [3:0]  req_after;
    int          d;          // cycles after ack before tx_done; 0 = never (timeout)
    int          exp_grant;
    logic [7:0]  exp_data;
    bit          exp_done;   // 1 = done pulse, 0 = err pulse
  } vec_t;

  vec_t vecs[NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard: byte presented with each tx_start ----------------
  always @(posedge clk) begin
    #1;
    if (tx_start === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_unexpected_start: tx_data 0x%0h, no frame expected", tx_data);
      end else begin
        sb_exp = exp_q.pop_front();
        check("sb_tx_data", tx_data, sb_exp);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Wait for IDLE, present a request, expect the grant one cycle later.
  task automatic start_frame(input logic [3:0] r, input logic [31:0] d,
                             input logic [3:0] r_after, input int eg,
                             input logic [7:0] ed);
    int c = 0;
    while (busy !== 1'b0 && c < 5000) begin
      tick();
      c++;
    end
    check("idle_reached", (c < 5000), 1);
    req      = r;
    req_data = d;
    exp_q.push_back(ed);
    tick();
    check("ack", ack, 1 << eg);
    check("tx_start", tx_start, 1);
    check("grant_id", grant_id, eg);
    check("tx_data", tx_data, ed);
    check("busy_start", busy, 1);
    req = r_after;
  endtask

  // Model the transmitter: pulse tx_done after d cycles, or never when d == 0.
  task automatic run_wait(input int d, input int eg, input logic [7:0] ed, input bit exp_done);
    int bad = 0;
    int n   = (d > 0) ? d : TIMEOUT_CYC;
    for (int j = 0; j < n; j++) begin
      tick();
      if (tx_data !== ed || tx_start !== 1'b0 || ack !== '0 || done !== '0 ||
          err !== '0 || busy !== 1'b1)
        bad++;
    end
    if (d > 0) tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    check("wait_quiet", bad, 0);
    check("done", done, exp_done ? (1 << eg) : 0);
    check("err", err, exp_done ? 0 : (1 << eg));
    check("tx_data_hold", tx_data, ed);
    check("state_gap", dbg_state, 3);
  endtask

  // Count the idle gap; optionally inject tx_done and a new request inside it.
  task automatic run_gap(input bit noise, input logic [3:0] nreq, input logic [31:0] ndata);
    int c   = 0;
    int bad = 0;
    if (noise) begin
      req      = nreq;
      req_data = ndata;
    end
    while (busy === 1'b1 && c < 200) begin
      if (noise && c == 3) tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      c++;
      if (ack !== '0 || tx_start !== 1'b0 || done !== '0 || err !== '0) bad++;
    end
    check("gap_len", c, GAP_CYC);
    check("gap_quiet", bad, 0);
    check("state_idle", dbg_state, 0);
  endtask

  // ---------------- test ----------------
  initial begin
    int bad;
    reset    = 1'b1;
    req      = '0;
    req_data = '0;
    tx_done  = 1'b0;

    vecs[0]  = '{4'b1111, 32'h13121110, 4'b1111, 3,           0, 8'h10, 1'b1};
    vecs[1]  = '{4'b1111, 32'h13121110, 4'b1111, 7,           1, 8'h11, 1'b1};
    vecs[2]  = '{4'b1111, 32'h13121110, 4'b1111, 1,           2, 8'h12, 1'b1};
    vecs[3]  = '{4'b1111, 32'h13121110, 4'b1111, 20,          3, 8'h13, 1'b1};
    vecs[4]  = '{4'b1001, 32'h13121110, 4'b1001, 2,           0, 8'h10, 1'b1};
    vecs[5]  = '{4'b1001, 32'h13121110, 4'b1001, 4,           3, 8'h13, 1'b1};
    vecs[6]  = '{4'b1111, 32'h13121110, 4'b0000, 5,           0, 8'h10, 1'b1};
    vecs[7]  = '{4'b0100, 32'h00AD0000, 4'b0000, 100,         2, 8'hAD, 1'b1};
    vecs[8]  = '{4'b0010, 32'h00005A00, 4'b0000, 0,           1, 8'h5A, 1'b0};
    vecs[9]  = '{4'b0110, 32'h00C37700, 4'b0000, TIMEOUT_CYC, 2, 8'hC3, 1'b1};
    vecs[10] = '{4'b1010, 32'hEE00DD00, 4'b0000, 1,           3, 8'hEE, 1'b1};

    repeat (3) tick();
    check("rst_outputs", {ack, done, err, tx_start, busy, tx_data, grant_id}, 0);
    check("rst_state", dbg_state, 0);
    reset = 1'b0;
    tick();

    // Table-driven frames.
    for (int i = 0; i < NVEC; i++) begin
      start_frame(vecs[i].req, vecs[i].data, vecs[i].req_after, vecs[i].exp_grant,
                  vecs[i].exp_data);
      run_wait(vecs[i].d, vecs[i].exp_grant, vecs[i].exp_data, vecs[i].exp_done);
      run_gap(1'b0, 4'b0000, 32'h0);
    end

    // tx_done while IDLE is ignored.
    bad = 0;
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    for (int j = 0; j < 3; j++) begin
      if (done !== '0 || err !== '0 || busy !== 1'b0 || tx_start !== 1'b0) bad++;
      tick();
    end
    check("idle_tx_done_ignored", bad, 0);

    // Request and tx_done arriving during GAP: ignored until IDLE, then acked.
    start_frame(4'b0001, 32'h000000A1, 4'b0000, 0, 8'hA1);
    run_wait(3, 0, 8'hA1, 1'b1);
    run_gap(1'b1, 4'b0100, 32'h00B70000);
    start_frame(4'b0100, 32'h00B70000, 4'b0000, 2, 8'hB7);
    run_wait(6, 2, 8'hB7, 1'b1);
    run_gap(1'b0, 4'b0000, 32'h0);

    // Reset in the middle of WAIT: outputs clear at once, no done/err afterwards.
    start_frame(4'b0010, 32'h00003C00, 4'b0000, 1, 8'h3C);
    repeat (10) tick();
    reset = 1'b1;
    #1;
    check("rst_mid_outputs", {ack, done, err, tx_start, busy, tx_data, grant_id}, 0);
    check("rst_mid_state", dbg_state, 0);
    tick();
    tick();
    reset = 1'b0;
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    bad = 0;
    for (int j = 0; j < 4; j++) begin
      if (done !== '0 || err !== '0 || busy !== 1'b0) bad++;
      tick();
    end
    check("rst_no_pulse", bad, 0);

    // Pointer restarts from 0 after reset.
    start_frame(4'b1111, 32'h13121110, 4'b0000, 0, 8'h10);
    run_wait(2, 0, 8'h10, 1'b1);
    run_gap(1'b0, 4'b0000, 32'h0);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
